card_dealer: RTL
================

# card_dealer

Datapath that answers the baccarat controller's active-low card-load strobes. It generates pseudo-random cards, captures them into six hand slots (three player, three dealer), and returns `pscore`, `dscore` and `pcard3` to the controller. It also counts dealt cards and flags strobe-protocol violations. It sits beside the controller on `slow_clock` and is the receiving end of its load/score interface.

## Interface
- `SEED`, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'h0001
- `slow_clock`  in  1  sole clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; takes priority over every other input
- `load_pcard1`, `load_pcard2`, `load_pcard3`  in  1 each  active-low player slot load strobes
- `load_dcard1`, `load_dcard2`, `load_dcard3`  in  1 each  active-low dealer slot load strobes
- `test_mode`  in  1  when high, the drawn card is `test_card` instead of the LFSR card
- `test_card`  in  4  forced rank; legal range 1..13
- `pscore`, `dscore`  out  4 each  hand totals mod 10, range 0..9
- `pcard3`  out  4  baccarat value of player slot 3, range 0..9
- `card_now`  out  4  rank that would be captured at the next edge, range 1..13
- `cards_dealt`  out  3  number of non-empty slots, range 0..6
- `proto_err`  out  1  sticky protocol-violation flag

## Operation
- **LFSR.** 16-bit Galois register that advances every cycle, including in test mode.
  - If `lfsr[0]` is 1: next = `(lfsr>>1) ^ 16'hB400`; otherwise next = `lfsr>>1`.
- **Drawn rank.**
  - `test_mode`=0: `card_now = (lfsr[7:0] mod 13) + 1`, computed from the current (pre-advance) LFSR state.
  - `test_mode`=1: `card_now = test_card`.
  - `card_now` is combinational.
- **Slots.** Six 4-bit registers. Value 0 means empty.
  - At each edge, every slot whose strobe is low captures `card_now`.
  - Several strobes low together: all of those slots capture the same rank.
- **Value map.** Rank 1..9 maps to its rank; rank 10..13 maps to 0; empty (0) maps to 0.
- **Scores.** Combinational from the slot registers.
  - `pscore` = (v(p1)+v(p2)+v(p3)) mod 10, using a 5-bit intermediate (maximum 27). `dscore` is computed the same way from the dealer slots.
  - `pcard3` = v(p3).
- **`cards_dealt`.** Each edge adds the number of slots that go from empty to non-empty. Overwriting a filled slot does not increment it. It never exceeds 6.
- **`proto_err`.** Set at an edge on either violation:
  - more than one strobe is low, or
  - a strobe is low for a slot that is already non-empty.
  
  The capture still happens on a violation. Only `reset` clears the flag.
- **Illegal `test_card`.** A value of 0 or 14..15 with `test_mode`=1 is captured as-is. `cards_dealt` counts it only if it is non-zero. Behaviour beyond that is not checked.

## Timing
- **Reset values:**
  - all slots, `pscore`, `dscore`, `pcard3`, `cards_dealt`, `proto_err` = 0
  - `lfsr` = `SEED`, or 16'h0001 if `SEED` = 0
  - `card_now` = (`SEED`[7:0] mod 13)+1 in the cycle after reset when `test_mode`=0
- **Capture latency.** A strobe low during cycle n causes the capture at the edge ending cycle n. The new slot value and the updated scores are visible in cycle n+1.
  - Consequence: a strobe in the controller's DC2 state yields valid scores in its ALLTWO state.
  - Consequence: a `load_pcard3` strobe is visible on `pcard3` in the following state.
- **Reset mid-deal.** `reset` high at an edge clears everything and reloads the LFSR. Any strobes low at that same edge are ignored.
- **No handshake or back-pressure.** Strobes are level-sampled once per edge. A strobe held low for k cycles captures k successive cards. From the second capture on, each one sets `proto_err`.
- **Gameplay.** The block never clears slots between hands. The controller resets between games.

## Test plan
- Reset with `SEED`=16'hACE1, `test_mode`=0, no strobes -> `card_now`=5 (0xE1=225, 225 mod 13=4); all outputs 0; one cycle later `card_now` changes per the LFSR.
- `test_mode`=1: `test_card`=9 with `load_pcard1` low for 1 cycle, then `test_card`=8 with `load_pcard2` low for 1 cycle -> `pscore`=7, `cards_dealt`=2, `proto_err`=0.
- Dealer ranks 13 then 12 into `dcard1` and `dcard2` -> `dscore`=0. Player ranks 9,9,9 into all three player slots -> `pscore`=7. Player rank 11 into `pcard3` -> `pcard3`=0.
- `load_pcard1` and `load_dcard1` low in the same cycle with `test_card`=4 -> both slots = 4, `pscore`=`dscore`=4, `cards_dealt`=2, `proto_err`=1.
- Reload `pcard1` (already filled) with rank 6 -> `pscore` updates to 6 + v(p2) + v(p3) mod 10, `cards_dealt` unchanged, `proto_err`=1.
- Full six-card deal, then `reset` asserted in the same cycle as `load_dcard3` -> the next cycle shows all slots 0, `cards_dealt`=0, `proto_err`=0, and the LFSR card sequence restarts identically.

Source files
------------

// File: rtl/card_dealer.sv
// Card-load datapath for the baccarat controller: LFSR card source, six hand
// slots, combinational scores, dealt-card counter and sticky protocol-error flag.
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    input  logic       test_mode,
    input  logic [3:0] test_card,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3,
    output logic [3:0] card_now,
    output logic [2:0] cards_dealt,
    output logic       proto_err
);

    // An all-zero Galois register would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'h0001 : SEED;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [3:0]  rank_rnd;
    logic [5:0]  ld;
    logic [3:0]  slot [6];
    logic [2:0]  n_low;
    logic [2:0]  n_fill;
    logic        hit_filled;
    logic [3:0]  dealt_sum;
    logic [2:0]  dealt_next;
    logic [4:0]  psum;
    logic [4:0]  dsum;

    function automatic logic [4:0] bval(input logic [3:0] r);
        bval = (r >= 4'd1 && r <= 4'd9) ? {1'b0, r} : 5'd0;
    endfunction

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign rank_rnd  = 4'(lfsr[7:0] % 8'd13) + 4'd1;
    assign card_now  = test_mode ? test_card : rank_rnd;

    // Slot order p1,p2,p3,d1,d2,d3; strobes inverted to active-high.
    assign ld = ~{load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

    always_comb begin
        n_low      = '0;
        n_fill     = '0;
        hit_filled = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (ld[i]) begin
                n_low = n_low + 3'd1;
                if (slot[i] != 4'd0)
                    hit_filled = 1'b1;
                else if (card_now != 4'd0)
                    n_fill = n_fill + 3'd1;
            end
        end
    end

    assign dealt_sum  = {1'b0, cards_dealt} + {1'b0, n_fill};
    assign dealt_next = (dealt_sum > 4'd6) ? 3'd6 : dealt_sum[2:0];

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            lfsr        <= SEED_EFF;
            cards_dealt <= '0;
            proto_err   <= 1'b0;
            for (int unsigned i = 0; i < 6; i++)
                slot[i] <= '0;
        end else begin
            lfsr        <= lfsr_next;
            cards_dealt <= dealt_next;
            if (n_low > 3'd1 || hit_filled)
                proto_err <= 1'b1;
            for (int unsigned i = 0; i < 6; i++)
                if (ld[i])
                    slot[i] <= card_now;
        end
    end

    assign psum   = bval(slot[0]) + bval(slot[1]) + bval(slot[2]);
    assign dsum   = bval(slot[3]) + bval(slot[4]) + bval(slot[5]);
    assign pscore = 4'(psum % 5'd10);
    assign dscore = 4'(dsum % 5'd10);
    assign pcard3 = 4'(bval(slot[2]));

endmodule
